// File: rtl/cam_driver.sv
// -----------------------------------------------------------------------------
// cam_driver
//   Synthesizable initiator for the CAM block. Host commands (INVALIDATE /
//   WRITE / READ / SEARCH) arrive over a valid/ready interface, are buffered
//   in a small FIFO, issued to the CAM one at a time as a one-cycle strobe,
//   and the CAM result captured CAM_LAT cycles later is returned as one
//   response per command, in command order, over a valid/ready interface.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready           host command handshake (cmd_ready = !full)
//   cmd_op/cmd_index/cmd_data     00 INVALIDATE, 01 WRITE, 10 READ, 11 SEARCH
//   resp_valid/resp_ready         response handshake
//   resp_op/hit/index/data        response payload, held until accepted
//   cam_write/read/search/invalidate  one-cycle CAM strobes
//   cam_index/cam_data_in         CAM index and write data / search key
//   cam_data_out/cam_read_valid   CAM read result
//   cam_found/cam_found_index     CAM search result
//   hit_count/miss_count          saturating SEARCH hit/miss counters
//
// Build option
//   CAM_DRIVER_STATS_EN : when defined, hit_count/miss_count are live
//                         counters; otherwise they are tied to zero.
// -----------------------------------------------------------------------------
module cam_driver #(
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int CAM_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_index,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [1:0]        resp_op,
  output logic              resp_hit,
  output logic [IDX_W-1:0]  resp_index,
  output logic [DATA_W-1:0] resp_data,
  output logic              cam_write,
  output logic              cam_read,
  output logic              cam_search,
  output logic              cam_invalidate,
  output logic [IDX_W-1:0]  cam_index,
  output logic [DATA_W-1:0] cam_data_in,
  input  logic [DATA_W-1:0] cam_data_out,
  input  logic              cam_read_valid,
  input  logic              cam_found,
  input  logic [IDX_W-1:0]  cam_found_index,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WAIT_W = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CAM_LAT - 1);

  typedef enum logic [1:0] {
    OP_INVALIDATE = 2'b00,
    OP_WRITE      = 2'b01,
    OP_READ       = 2'b10,
    OP_SEARCH     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  op_e               r_fifo_op   [FIFO_DEPTH];
  logic [IDX_W-1:0]  r_fifo_idx  [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [PTR_W:0]    w_count_nxt;
  logic              r_cmd_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_empty;
  op_e               w_head_op;

  assign w_push       = cmd_valid && r_cmd_ready;
  assign w_fifo_empty = (r_count == '0);
  assign w_head_op    = r_fifo_op[r_rd_ptr];
  assign cmd_ready    = r_cmd_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + (PTR_W+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_op[r_wr_ptr]   <= op_e'(cmd_op);
      r_fifo_idx[r_wr_ptr]  <= cmd_index;
      r_fifo_data[r_wr_ptr] <= cmd_data;
    end
  end

  // cmd_ready is registered from the next occupancy, so it is low in reset
  // and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_nxt;
      r_cmd_ready <= (w_count_nxt != FULL_CNT);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_e            r_state;
  state_e            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_capture;
  logic              w_resp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_fifo_empty)            w_state_nxt = S_ISSUE;
      S_ISSUE:                               w_state_nxt = S_WAIT;
      S_WAIT:  if (r_wait_cnt == WAIT_LAST)  w_state_nxt = S_RESP;
      S_RESP:  if (resp_ready)               w_state_nxt = S_IDLE;
      default:                               w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_resp_valid = 1'b0;
    unique case (r_state)
      S_IDLE:  w_pop        = !w_fifo_empty;
      S_WAIT:  w_capture    = (r_wait_cnt == WAIT_LAST);
      S_RESP:  w_resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_valid = w_resp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Command register and CAM strobes
  // ---------------------------------------------------------------------------
  op_e               r_cmd_op;
  logic [IDX_W-1:0]  r_cmd_index;
  logic              r_cam_write;
  logic              r_cam_read;
  logic              r_cam_search;
  logic              r_cam_invalidate;
  logic [IDX_W-1:0]  r_cam_index;
  logic [DATA_W-1:0] r_cam_data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_op    <= OP_INVALIDATE;
      r_cmd_index <= '0;
    end else if (w_pop) begin
      r_cmd_op    <= w_head_op;
      r_cmd_index <= r_fifo_idx[r_rd_ptr];
    end
  end

  // Strobe and bus registers load from the FIFO head on the pop edge, so they
  // are valid exactly for the ISSUE cycle and return to zero on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cam_write      <= 1'b0;
      r_cam_read       <= 1'b0;
      r_cam_search     <= 1'b0;
      r_cam_invalidate <= 1'b0;
      r_cam_index      <= '0;
      r_cam_data_in    <= '0;
    end else if (w_pop) begin
      r_cam_write      <= (w_head_op == OP_WRITE);
      r_cam_read       <= (w_head_op == OP_READ);
      r_cam_search     <= (w_head_op == OP_SEARCH);
      r_cam_invalidate <= (w_head_op == OP_INVALIDATE);
      r_cam_index      <= r_fifo_idx[r_rd_ptr];
      r_cam_data_in    <= r_fifo_data[r_rd_ptr];
    end else begin
      r_cam_write      <= 1'b0;
      r_cam_read       <= 1'b0;
      r_cam_search     <= 1'b0;
      r_cam_invalidate <= 1'b0;
      r_cam_index      <= '0;
      r_cam_data_in    <= '0;
    end
  end

  assign cam_write      = r_cam_write;
  assign cam_read       = r_cam_read;
  assign cam_search     = r_cam_search;
  assign cam_invalidate = r_cam_invalidate;
  assign cam_index      = r_cam_index;
  assign cam_data_in    = r_cam_data_in;

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------
  logic [1:0]        r_resp_op;
  logic              r_resp_hit;
  logic [IDX_W-1:0]  r_resp_index;
  logic [DATA_W-1:0] r_resp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_op    <= '0;
      r_resp_hit   <= 1'b0;
      r_resp_index <= '0;
      r_resp_data  <= '0;
    end else if (w_capture) begin
      r_resp_op <= r_cmd_op;
      unique case (r_cmd_op)
        OP_READ: begin
          r_resp_hit   <= cam_read_valid;
          r_resp_index <= r_cmd_index;
          r_resp_data  <= cam_data_out;
        end
        OP_SEARCH: begin
          r_resp_hit   <= cam_found;
          r_resp_index <= cam_found ? cam_found_index : '0;
          r_resp_data  <= '0;
        end
        default: begin
          r_resp_hit   <= 1'b0;
          r_resp_index <= r_cmd_index;
          r_resp_data  <= '0;
        end
      endcase
    end
  end

  assign resp_op    = r_resp_op;
  assign resp_hit   = r_resp_hit;
  assign resp_index = r_resp_index;
  assign resp_data  = r_resp_data;

  // ---------------------------------------------------------------------------
  // Search statistics
  // ---------------------------------------------------------------------------
`ifdef CAM_DRIVER_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_capture && (r_cmd_op == OP_SEARCH)) begin
      if (cam_found) begin
        if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
      end else begin
        if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cam_driver.sv
// -----------------------------------------------------------------------------
// tb_cam_driver
//   Bench for cam_driver: a behavioural CAM answers the strobes with CAM_LAT
//   latency (driving random junk whenever no result is due), and an
//   array-based reference CAM predicts every response at command-accept time.
// -----------------------------------------------------------------------------
module tb_cam_driver;

  localparam int DW  = 32;
  localparam int IW  = 5;
  localparam int FD  = 4;
  localparam int LAT = 1;
  localparam int NENT = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [IW-1:0] cmd_index;
  logic [DW-1:0] cmd_data;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [1:0]    resp_op;
  logic          resp_hit;
  logic [IW-1:0] resp_index;
  logic [DW-1:0] resp_data;
  logic          cam_write, cam_read, cam_search, cam_invalidate;
  logic [IW-1:0] cam_index;
  logic [DW-1:0] cam_data_in;
  logic [DW-1:0] cam_data_out;
  logic          cam_read_valid;
  logic          cam_found;
  logic [IW-1:0] cam_found_index;
  logic [15:0]   hit_count, miss_count;

  cam_driver #(
    .DATA_W(DW), .IDX_W(IW), .FIFO_DEPTH(FD), .CAM_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_index(cmd_index), .cmd_data(cmd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
    .resp_hit(resp_hit), .resp_index(resp_index), .resp_data(resp_data),
    .cam_write(cam_write), .cam_read(cam_read), .cam_search(cam_search),
    .cam_invalidate(cam_invalidate), .cam_index(cam_index),
    .cam_data_in(cam_data_in), .cam_data_out(cam_data_out),
    .cam_read_valid(cam_read_valid), .cam_found(cam_found),
    .cam_found_index(cam_found_index),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural CAM attached to the DUT
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem_d [NENT] = '{default: '0};
  logic          mem_v [NENT] = '{default: 1'b0};
  logic          pv  [LAT] = '{default: 1'b0};
  logic [DW-1:0] pd  [LAT];
  logic          prv [LAT];
  logic          pf  [LAT];
  logic [IW-1:0] pfi [LAT];
  logic [63:0]   junk = '0;

  always @(negedge clk) junk = {$urandom, $urandom};

  always @(posedge clk) begin
    logic          f;
    logic [IW-1:0] fi;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; prv[i] <= prv[i-1];
      pf[i] <= pf[i-1]; pfi[i] <= pfi[i-1];
    end
    f = 1'b0; fi = '0;
    for (int i = 0; i < NENT; i++)
      if (!f && mem_v[i] && mem_d[i] == cam_data_in) begin f = 1'b1; fi = IW'(i); end
    pv[0]  <= cam_write | cam_read | cam_search | cam_invalidate;
    pd[0]  <= mem_d[cam_index];
    prv[0] <= mem_v[cam_index];
    pf[0]  <= f;
    pfi[0] <= fi;
    if (cam_write) begin mem_v[cam_index] <= 1'b1; mem_d[cam_index] <= cam_data_in; end
    if (cam_invalidate) mem_v[cam_index] <= 1'b0;
  end

  assign cam_data_out    = pv[LAT-1] ? pd[LAT-1]  : junk[31:0];
  assign cam_read_valid  = pv[LAT-1] ? prv[LAT-1] : junk[32];
  assign cam_found       = pv[LAT-1] ? pf[LAT-1]  : junk[33];
  assign cam_found_index = pv[LAT-1] ? pfi[LAT-1] : junk[38:34];

  // ---------------------------------------------------------------------------
  // Reference model: responses predicted in command order at accept time
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ref_d [NENT] = '{default: '0};
  logic          ref_v [NENT] = '{default: 1'b0};
  logic [39:0]   q_exp[$];    // {op, hit, index, data}
  logic [38:0]   q_issue[$];  // {op, index, data}
  int ref_hit = 0, ref_miss = 0;

  task automatic model_push(input logic [1:0] op, input logic [IW-1:0] idx, input logic [DW-1:0] d);
    logic          h;
    logic [IW-1:0] ri;
    logic [DW-1:0] rd;
    h = 1'b0; ri = idx; rd = '0;
    case (op)
      2'b00: ref_v[idx] = 1'b0;
      2'b01: begin ref_v[idx] = 1'b1; ref_d[idx] = d; end
      2'b10: begin h = ref_v[idx]; rd = ref_d[idx]; end
      default: begin
        ri = '0;
        for (int i = 0; i < NENT; i++)
          if (!h && ref_v[i] && ref_d[i] == d) begin h = 1'b1; ri = IW'(i); end
        if (h) ref_hit++; else ref_miss++;
      end
    endcase
    q_exp.push_back({op, h, ri, rd});
    q_issue.push_back({op, idx, d});
  endtask

  // ---------------------------------------------------------------------------
  // Monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  int          n_strobes = 0;
  int          n_resp = 0;
  int          q_rcyc[$];
  logic        prev_hold = 1'b0;
  logic [39:0] prev_pl = '0;

  always @(negedge clk) begin
    int          ns;
    logic [1:0]  sop;
    logic [38:0] it;
    cyc++;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) model_push(cmd_op, cmd_index, cmd_data);
      ns = $countones({cam_write, cam_read, cam_search, cam_invalidate});
      if (ns != 0) begin
        n_strobes++;
        chk("strobe_onehot", 64'(ns), 64'd1);
        sop = cam_search ? 2'b11 : cam_read ? 2'b10 : cam_write ? 2'b01 : 2'b00;
        if (q_issue.size() == 0) begin
          chk("strobe_unexpected", 64'(ns), 64'd0);
        end else begin
          it = q_issue.pop_front();
          chk("issue_op",   64'(sop),         64'(it[38:37]));
          chk("issue_idx",  64'(cam_index),   64'(it[36:32]));
          chk("issue_data", 64'(cam_data_in), 64'(it[31:0]));
        end
      end else begin
        chk("bus_idle", {27'd0, cam_index, cam_data_in}, 64'd0);
      end
      if (prev_hold)
        chk("resp_stable", {23'd0, resp_valid, resp_op, resp_hit, resp_index, resp_data},
            {23'd0, 1'b1, prev_pl});
      prev_hold = resp_valid && !resp_ready;
      prev_pl   = {resp_op, resp_hit, resp_index, resp_data};
      if (resp_valid && resp_ready) begin
        n_resp++;
        q_rcyc.push_back(cyc);
        if (q_exp.size() == 0)
          chk("resp_unexpected", 64'(resp_valid), 64'd0);
        else
          chk("resp", {24'd0, resp_op, resp_hit, resp_index, resp_data}, {24'd0, q_exp.pop_front()});
      end
    end
  end

  // resp_ready driver: 0 = always ready, 1 = random, 2 = held low
  int rr_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = 1'($urandom_range(0, 1));
      default: resp_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (entered and left at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic push(input logic [1:0] op, input logic [IW-1:0] idx, input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_index = idx; cmd_data = d;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      done = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!done) chk("push_timeout", 64'(cmd_ready), 64'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 2000 && !idle; k++) begin
      @(negedge clk);
      idle = (q_exp.size() == 0) && (q_issue.size() == 0) && !resp_valid;
    end
    if (!idle) chk("idle_timeout", 64'(q_exp.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_stats(input string tag);
    int eh, em;
`ifdef CAM_DRIVER_STATS_EN
    eh = ref_hit; em = ref_miss;
`else
    eh = 0; em = 0;
`endif
    chk({tag, "_hit"},  64'(hit_count),  64'(eh));
    chk({tag, "_miss"}, 64'(miss_count), 64'(em));
  endtask

  logic [DW-1:0] pool [4] = '{32'hDEADBEEF, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000};

  initial begin
    int s_lat, r_lat, base_s, base_r;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_index = '0; cmd_data = '0;
    rr_mode = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {56'd0, cmd_ready, resp_valid, cam_write, cam_read, cam_search,
                    cam_invalidate, resp_op} | {63'd0, resp_hit}, 64'd0);
    chk("rst_bus",   {27'd0, cam_index, cam_data_in}, 64'd0);
    chk("rst_resp",  {27'd0, resp_index, resp_data}, 64'd0);
    chk("rst_stats", {32'd0, hit_count, miss_count}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // WRITE with latency measurement relative to the accept edge:
    // strobe visible after 1 edge, resp_valid after 2+LAT edges.
    push(2'b01, 5'd3, 32'hDEADBEEF);
    s_lat = 0; r_lat = 0;
    for (int e = 1; e <= 10; e++) begin
      if (e > 1) begin @(posedge clk); #1; end
      else #0;
      if (e == 1) begin @(posedge clk); #1; end
      if (s_lat == 0 && (cam_write | cam_read | cam_search | cam_invalidate)) s_lat = e;
      if (r_lat == 0 && resp_valid) r_lat = e;
    end
    chk("lat_strobe", 64'(s_lat), 64'd1);
    chk("lat_resp",   64'(r_lat), 64'(2 + LAT));
    wait_idle();
    push(2'b10, 5'd3, 32'h0);
    wait_idle();

    // Back-to-back searches: hit then miss; response spacing 3+LAT cycles
    q_rcyc.delete();
    push(2'b11, 5'd0, 32'hDEADBEEF);
    push(2'b11, 5'd7, 32'h0);
    wait_idle();
    if (q_rcyc.size() == 2) chk("throughput", 64'(q_rcyc[1] - q_rcyc[0]), 64'(3 + LAT));
    else chk("throughput_count", 64'(q_rcyc.size()), 64'd2);
    check_stats("stats_dir");

    // INVALIDATE then READ
    push(2'b00, 5'd3, 32'h0);
    push(2'b10, 5'd3, 32'h0);
    wait_idle();

    // Host backpressure: one in flight, four buffered, FIFO full
    rr_mode = 2;
    @(posedge clk); #1;
    base_s = n_strobes; base_r = n_resp;
    for (int i = 0; i < 5; i++) push(2'b10, IW'(i), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_ready",   64'(cmd_ready), 64'd0);
    chk("bp_strobes", 64'(n_strobes - base_s), 64'd1);
    rr_mode = 0;
    wait_idle();
    chk("bp_drained", 64'(n_resp - base_r), 64'd5);

    // Reset while a READ is waiting for the CAM
    push(2'b10, 5'd5, 32'h0);
    for (int k = 0; k < 20 && !cam_read; k++) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    q_exp.delete(); q_issue.delete();
    ref_hit = 0; ref_miss = 0;
    #1;
    chk("rst_mid_ctl", {58'd0, cmd_ready, resp_valid, cam_write, cam_read, cam_search,
                        cam_invalidate}, 64'd0);
    chk("rst_mid_stats", {32'd0, hit_count, miss_count}, 64'd0);
    base_s = n_strobes; base_r = n_resp;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", 64'(cmd_ready), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_no_resp",   64'(n_resp - base_r), 64'd0);
    chk("rst_mid_no_strobe", 64'(n_strobes - base_s), 64'd0);

    // Randomized traffic with random host backpressure
    rr_mode = 1;
    for (int n = 0; n < 80; n++) begin
      push(2'($urandom_range(0, 3)), IW'($urandom_range(0, 5)), pool[$urandom_range(0, 3)]);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rr_mode = 0;
    wait_idle();
    check_stats("stats_rand");
    chk("final_ready", 64'(cmd_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/cam_driver.md
Name: cam_driver

Overview:
- Hardware initiator for the team's CAM block.
- Accepts host commands (WRITE / READ / SEARCH / INVALIDATE) over a valid/ready interface and buffers them in a small command FIFO.
- Issues each command to the CAM as a one-cycle strobe, captures the CAM result after a fixed latency, and returns one response per command over a valid/ready interface.
- Takes the place of the bench as the synthesizable driving end of the CAM interface.

Parameters:
DATA_W, 32, CAM entry data width
IDX_W, 5, CAM index width (2**IDX_W entries)
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
CAM_LAT, 1, cycles from CAM strobe to CAM result valid (>=1)

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO not full
cmd_op  in  2  00 INVALIDATE, 01 WRITE, 10 READ, 11 SEARCH
cmd_index  in  IDX_W  target index (ignored for SEARCH)
cmd_data  in  DATA_W  write data or search key
resp_valid  out  1  response valid
resp_ready  in  1  host accepts response
resp_op  out  2  echo of the command op
resp_hit  out  1  SEARCH: match found; READ: entry valid; else 0
resp_index  out  IDX_W  SEARCH: matching index; else echo of cmd_index
resp_data  out  DATA_W  READ: entry data; else 0
cam_write  out  1  CAM write strobe
cam_read  out  1  CAM read strobe
cam_search  out  1  CAM search strobe
cam_invalidate  out  1  CAM invalidate strobe
cam_index  out  IDX_W  CAM index
cam_data_in  out  DATA_W  CAM write data / key
cam_data_out  in  DATA_W  CAM read data
cam_read_valid  in  1  CAM read entry-valid flag
cam_found  in  1  CAM search hit
cam_found_index  in  IDX_W  CAM search hit index
hit_count  out  16  search hit counter (see Optional Feature)
miss_count  out  16  search miss counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied; FSM to IDLE.
  - All cam_* strobes, resp_valid and counters go to 0 immediately; all outputs 0.
  - cmd_ready rises on the first clk edge after rst_n deasserts.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full, registered.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. At most one command outstanding.
  - IDLE: if FIFO non-empty, pop the head into the command register, then go to ISSUE.
  - ISSUE: exactly one strobe matching op is high for one cycle. cam_index and cam_data_in are driven from the command register. Next state WAIT.
  - WAIT: count CAM_LAT cycles. At the last edge, capture CAM result outputs into the response register, then go to RESP.
  - RESP: resp_valid=1, payload stable until resp_ready. On resp_valid && resp_ready, go to IDLE.
- Strobes and cam_index/cam_data_in are registered; they are 0 outside ISSUE.
- Timing: command pushed at edge t:
  - strobe is high in cycle t+2;
  - resp_valid first high in cycle t+2+CAM_LAT+1.
  - With CAM_LAT=1, minimum command-to-response latency is 4 cycles.
  - Back-to-back throughput is 1 command per (3+CAM_LAT) cycles with resp_ready held high.
- Response fields by op:
  - WRITE / INVALIDATE: resp_hit=0, resp_data=0, resp_index=cmd_index.
  - READ: resp_hit=cam_read_valid, resp_data=cam_data_out, resp_index=cmd_index.
  - SEARCH: resp_hit=cam_found, resp_index=cam_found_index when hit else 0, resp_data=0.
- Responses are returned in command order.
- Host backpressure: while in RESP, no new CAM strobe is issued. The FIFO keeps accepting commands until full.
- Reset mid-operation: an in-flight command and its response are discarded; no response is produced.

Optional Feature:
- Macro: CAM_DRIVER_STATS_EN.
- Defined:
  - hit_count / miss_count increment on each SEARCH capture with cam_found=1 / 0.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: no counter logic is built; hit_count and miss_count are tied to 0.

Test Plan:
- WRITE idx 3 data 32'hDEADBEEF, then READ idx 3 -> cam_write pulses once with cam_index=3. READ response: op=10, hit=1, data=32'hDEADBEEF, index=3. Response appears 4 cycles after push (CAM_LAT=1).
- SEARCH key 32'hDEADBEEF after the above -> resp_hit=1, resp_index=3. SEARCH key 32'h0 -> resp_hit=0, resp_index=0. With CAM_DRIVER_STATS_EN: hit_count=1, miss_count=1.
- INVALIDATE idx 3, then READ idx 3 -> INVALIDATE response hit=0. READ response hit=0.
- Hold resp_ready=0 and push 5 commands (FIFO_DEPTH=4) -> one command is in flight, 4 are buffered, and cmd_ready=0 afterwards. Only one strobe is issued. Releasing resp_ready drains all 5 responses in order.
- Assert rst_n=0 during WAIT of a READ -> strobes and resp_valid go to 0 asynchronously. After release: no response, FIFO empty, cmd_ready=1.
